stopwatch_time_counter: RTL and testbench

- Downstream consumer of the clock-divider output. Converts the divider's slow square wave (`tick_in`) into a running MM:SS BCD time value.
- Provides start/pause/clear control through a small state machine.
- Everything runs on the single system clock. `tick_in` is treated as data and edge-detected internally; it is never used as a clock.
- Feeds the display-multiplexing stage with four BCD digits.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/bcd_digit.sv | 32 +++
 rtl/stopwatch_time_counter.sv | 124 ++++++++++++
 tb/tb_stopwatch_time_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared widths, default digit limits and FSM state encoding for the stopwatch.
package stopwatch_pkg;

    localparam int BCD_W            = 4;
    localparam int SEC_TENS_MAX_DEF = 5;
    localparam int MIN_TENS_MAX_DEF = 5;
    localparam int ONES_MAX_DEF     = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } sw_state_t;

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit: counts 0..MAX on en, wraps to 0 and raises carry at MAX.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MAX = ONES_MAX_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    localparam logic [BCD_W-1:0] MAX_V = BCD_W'(MAX);

    logic [BCD_W-1:0] r_q;
    logic             w_at_max;

    assign w_at_max = (r_q == MAX_V);
    assign carry    = en & w_at_max;
    assign q        = r_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= w_at_max ? '0 : r_q + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_time_counter.sv
// MM:SS BCD stopwatch driven by an edge-detected slow tick, with start/pause/clear FSM.
// state  | meaning
// IDLE   | time held at 00:00, not counting
// RUN    | counting one second per tick rise
// PAUSED | time frozen at its last value
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF,
    parameter int MIN_TENS_MAX = MIN_TENS_MAX_DEF,
    parameter int ONES_MAX     = ONES_MAX_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             start_stop,
    input  logic             clear,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic             running,
    output logic             rollover
);

    logic      r_tick_q, r_ss_q, r_clr_q;
    logic      w_rise_tick, w_rise_ss, w_rise_clr;
    sw_state_t r_state, w_next;
    logic      r_running, r_rollover;
    logic      w_inc, w_clr_digits;
    logic      w_so_carry, w_st_carry, w_mo_carry, w_mt_carry;

    // Button history resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_q <= 1'b0;
            r_ss_q   <= 1'b1;
            r_clr_q  <= 1'b1;
        end else begin
            r_tick_q <= tick_in;
            r_ss_q   <= start_stop;
            r_clr_q  <= clear;
        end
    end

    assign w_rise_tick = tick_in & ~r_tick_q;
    assign w_rise_ss   = start_stop & ~r_ss_q;
    assign w_rise_clr  = clear & ~r_clr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_running  <= 1'b0;
            r_rollover <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_running  <= (w_next == RUN);
            r_rollover <= w_mt_carry;
        end
    end

    // Clear beats start_stop whenever clear is honoured (outside RUN).
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_rise_clr)     w_next = IDLE;
                else if (w_rise_ss) w_next = RUN;
            end
            RUN: begin
                if (w_rise_ss)      w_next = PAUSED;
            end
            PAUSED: begin
                if (w_rise_clr)     w_next = IDLE;
                else if (w_rise_ss) w_next = RUN;
            end
            default: w_next = IDLE;
        endcase
    end

    // Registered state gates the count: the pausing tick counts, the starting tick does not.
    assign w_inc        = (r_state == RUN) & w_rise_tick;
    assign w_clr_digits = w_rise_clr & (r_state != RUN);

    bcd_digit #(.MAX(ONES_MAX)) u_sec_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr_digits),
        .en    (w_inc),
        .q     (sec_ones),
        .carry (w_so_carry)
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr_digits),
        .en    (w_so_carry),
        .q     (sec_tens),
        .carry (w_st_carry)
    );

    bcd_digit #(.MAX(ONES_MAX)) u_min_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr_digits),
        .en    (w_st_carry),
        .q     (min_ones),
        .carry (w_mo_carry)
    );

    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr_digits),
        .en    (w_mo_carry),
        .q     (min_tens),
        .carry (w_mt_carry)
    );

    assign running  = r_running;
    assign rollover = r_rollover;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Stopwatch bench: directed scenarios plus random stimulus against a seconds-count reference model.
module tb_stopwatch_time_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_in = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, rollover;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: elapsed seconds as one integer, state as a small code.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2;
    int m_secs = 0;
    int m_st   = M_IDLE;
    int m_roll = 0;
    bit m_tq = 0, m_sq = 1, m_cq = 1;
    int roll_seen;

    stopwatch_time_counter dut (
        .clk        (clk),
        .reset      (reset),
        .tick_in    (tick_in),
        .start_stop (start_stop),
        .clear      (clear),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .running    (running),
        .rollover   (rollover)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit t, input bit s, input bit c, input bit r);
        bit rt, rs, rc;
        if (r) begin
            m_secs = 0; m_st = M_IDLE; m_roll = 0;
            m_tq = 0; m_sq = 1; m_cq = 1;
            return;
        end
        rt = t & ~m_tq;
        rs = s & ~m_sq;
        rc = c & ~m_cq;
        m_roll = 0;
        if (m_st == M_RUN && rt) begin
            m_secs = m_secs + 1;
            if (m_secs == 3600) begin
                m_secs = 0;
                m_roll = 1;
            end
        end
        if (m_st != M_RUN && rc) begin
            m_st   = M_IDLE;
            m_secs = 0;
        end else if (rs) begin
            m_st = (m_st == M_RUN) ? M_PAUSED : M_RUN;
        end
        m_tq = t; m_sq = s; m_cq = c;
    endtask

    task automatic compare_all();
        check("sec_ones", 32'(sec_ones), 32'(m_secs % 10));
        check("sec_tens", 32'(sec_tens), 32'((m_secs / 10) % 6));
        check("min_ones", 32'(min_ones), 32'((m_secs / 60) % 10));
        check("min_tens", 32'(min_tens), 32'(m_secs / 600));
        check("running",  32'(running),  32'(m_st == M_RUN));
        check("rollover", 32'(rollover), 32'(m_roll));
    endtask

    // Drive one cycle of inputs mid-period, advance the model at the edge, compare on the falling edge.
    task automatic step(input bit t, input bit s, input bit c, input bit r);
        tick_in = t; start_stop = s; clear = c; reset = r;
        @(posedge clk);
        model_update(t, s, c, r);
        @(negedge clk);
        compare_all();
        if (rollover === 1'b1) roll_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
    endtask

    task automatic expect_time(input string tag, input int mm, input int ss);
        check({tag, "_min"}, 32'({min_tens, min_ones}), 32'(((mm / 10) << 4) | (mm % 10)));
        check({tag, "_sec"}, 32'({sec_tens, sec_ones}), 32'(((ss / 10) << 4) | (ss % 10)));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        // Reset with start_stop held, then ticks: nothing may start.
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0);
            step(0, 1, 0, 0);
        end
        expect_time("reset_hold", 0, 0);
        check("reset_hold_running", 32'(running), 32'd0);
        step(0, 0, 0, 0);

        // Start and count 75 seconds.
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        ticks(75);
        expect_time("count75", 1, 15);
        check("count75_running", 32'(running), 32'd1);

        // Preload to 59:58, then cross the wrap.
        ticks(3598 - 75);
        expect_time("preload", 59, 58);
        ticks(1);
        expect_time("max", 59, 59);
        roll_seen = 0;
        ticks(1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        expect_time("wrap", 0, 0);
        check("wrap_roll_cycles", 32'(roll_seen), 32'd1);
        check("wrap_running", 32'(running), 32'd1);

        // Clear ignored in RUN; pause press coinciding with a tick still counts it.
        ticks(9);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        expect_time("clear_in_run", 0, 9);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        expect_time("pause_tick", 0, 10);
        check("pause_running", 32'(running), 32'd0);
        ticks(5);
        expect_time("paused_frozen", 0, 10);

        // Clear and start together in PAUSED: clear wins.
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        expect_time("clear_wins", 0, 0);
        check("clear_wins_running", 32'(running), 32'd0);

        // Tick on the starting cycle is not counted.
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        expect_time("start_tick", 0, 0);
        check("start_tick_running", 32'(running), 32'd1);

        // Held tick counts once.
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        expect_time("held_tick", 0, 1);

        // Reset mid-run at 12:34.
        ticks(754 - 1);
        expect_time("pre_reset", 12, 34);
        step(0, 0, 0, 1);
        expect_time("mid_reset", 0, 0);
        check("mid_reset_running", 32'(running), 32'd0);
        step(0, 0, 0, 0);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            step(bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 11) == 0),
                 bit'($urandom_range(0, 40) == 0),
                 bit'($urandom_range(0, 400) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
